// File: rtl/bus_cycle_controller_pkg.sv
// bus_cycle_controller_pkg: bus select codes, controller state encodings, cycle types
package bus_cycle_controller_pkg;
    localparam logic [1:0] ADDR_BUSX_PC_A      = 2'd0;
    localparam logic [1:0] ADDR_BUSX_ALU_R     = 2'd1;
    localparam logic [1:0] ADDR_BUSX_ALUB_DATA = 2'd2;
    localparam logic [1:0] DATA_BUSX_REGA_DOUT = 2'd0;
    localparam logic [1:0] DATA_BUSX_ALU_R     = 2'd1;
    localparam logic [2:0] BCC_ST_IDLE   = 3'd0;
    localparam logic [2:0] BCC_ST_SETUP  = 3'd1;
    localparam logic [2:0] BCC_ST_STROBE = 3'd2;
    localparam logic [2:0] BCC_ST_WAIT   = 3'd3;
    localparam logic [2:0] BCC_ST_HOLD   = 3'd4;
    typedef enum logic [1:0] {CT_NULL, CT_READ, CT_WRITE, CT_FAULT} cycle_t;
    // a single-lane bus still carries a 1-bit lane index that is always zero
    function automatic int lane_bits(input int dw);
        return (dw / 8 > 1) ? $clog2(dw / 8) : 1;
    endfunction
endpackage

// File: rtl/bus_cycle_controller_steer.sv
// byte_lane_steer: write byte placement, per-lane strobe mask and read byte extraction
module byte_lane_steer
    import bus_cycle_controller_pkg::*;
#(
    parameter int DW = 16,
    localparam int LANES = DW / 8,
    localparam int LW = lane_bits(DW)
) (
    input  logic [LW-1:0]    lane_i,
    input  logic [7:0]       wbyte_i,
    input  logic [DW-1:0]    rdata_i,
    output logic [DW-1:0]    wdata_o,
    output logic [LANES-1:0] mask_o,
    output logic [DW-1:0]    rbyte_o
);
    assign wdata_o = DW'(wbyte_i) << {lane_i, 3'b000};
    assign mask_o  = LANES'(1) << lane_i;
    assign rbyte_o = (rdata_i >> {lane_i, 3'b000}) & DW'(8'hFF);
endmodule

// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller: registered bus-cycle FSM with READY wait states and byte lanes.
// Define BUS_CYCLE_TIMEOUT_EN to abort a cycle after WAIT_MAX READY-low wait cycles.
module bus_cycle_controller
    import bus_cycle_controller_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int WAIT_MAX = 15,
    localparam int LANES = DW / 8,
    localparam int LW = lane_bits(DW)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ,
    input  logic [1:0]       ADDR_BUSX,
    input  logic [AW-1:0]    PC_A,
    input  logic [AW-1:0]    ALU_R,
    input  logic [AW-1:0]    ALUB_DATA,
    input  logic [DW-1:0]    REGA_DOUT,
    input  logic [1:0]       DATA_BUSX,
    input  logic             BYTEX,
    input  logic             WRX,
    input  logic             RDX,
    input  logic             READY,
    input  logic [DW-1:0]    DIN_BUS,
    output logic [AW-1:0]    ADDR_BUF,
    output logic [DW-1:0]    DOUT_BUF,
    output logic [LANES-1:0] WRN_BUF,
    output logic             RDN_BUF,
    output logic             DBUS_OEN,
    output logic [DW-1:0]    DIN_OUT,
    output logic             BUSY,
    output logic             ACK,
    output logic             ERR
);
    logic [2:0]       state_q, state_d;
    cycle_t           ct_q, ct_d;
    logic             byte_q;
    logic [LW-1:0]    lane_q, lane_d;
    logic [AW-1:0]    addr_q, sel_addr;
    logic [DW-1:0]    dout_q, din_q, wdata, steer_wdata, rbyte;
    logic [LANES-1:0] wrn_q, mask;
    logic             rdn_q, oen_q, accept, quick, to_hold, abort;

    if (DW % 8 != 0 || DW < 8 || WAIT_MAX < 1) begin : g_bad_cfg
        $error("bus_cycle_controller: DW must be a multiple of 8 and WAIT_MAX at least 1");
    end

    assign sel_addr = ADDR_BUSX == ADDR_BUSX_PC_A  ? PC_A
                    : ADDR_BUSX == ADDR_BUSX_ALU_R ? ALU_R : ALUB_DATA;
    assign lane_d   = LW'(sel_addr % AW'(LANES));
    assign accept   = state_q == BCC_ST_IDLE && REQ;
    // the steer unit serves the incoming request in IDLE and the latched lane afterwards
    byte_lane_steer #(.DW(DW)) u_steer (
        .lane_i  (state_q == BCC_ST_IDLE ? lane_d : lane_q),
        .wbyte_i (REGA_DOUT[7:0]),
        .rdata_i (DIN_BUS),
        .wdata_o (steer_wdata),
        .mask_o  (mask),
        .rbyte_o (rbyte)
    );
    assign wdata   = DATA_BUSX != DATA_BUSX_REGA_DOUT ? DW'(ALU_R) : BYTEX ? steer_wdata : REGA_DOUT;
    assign ct_d    = (RDX && WRX) || (!BYTEX && lane_d != '0) ? CT_FAULT
                   : WRX ? CT_WRITE : RDX ? CT_READ : CT_NULL;
    assign quick   = ct_q == CT_FAULT || ct_q == CT_NULL;
    assign to_hold = (state_q == BCC_ST_STROBE && (READY || quick)) ||
                     (state_q == BCC_ST_WAIT && (READY || abort));

`ifdef BUS_CYCLE_TIMEOUT_EN
    localparam int CW = $clog2(WAIT_MAX + 1);
    logic [CW-1:0] cnt_q;
    assign abort = state_q == BCC_ST_WAIT && !READY && cnt_q == CW'(WAIT_MAX - 1);
    always_ff @(posedge CLK)
        cnt_q <= RESET || state_q != BCC_ST_WAIT ? '0 : cnt_q + 1'b1;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q == BCC_ST_IDLE   ? (REQ ? BCC_ST_SETUP : BCC_ST_IDLE)
                : state_q == BCC_ST_SETUP  ? BCC_ST_STROBE
                : to_hold                  ? BCC_ST_HOLD
                : state_q == BCC_ST_STROBE || state_q == BCC_ST_WAIT ? BCC_ST_WAIT
                : BCC_ST_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= BCC_ST_IDLE;
            ct_q    <= CT_NULL;
            byte_q  <= 1'b0;
            lane_q  <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            din_q   <= '0;
            wrn_q   <= '1;
            rdn_q   <= 1'b1;
            oen_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= sel_addr;
                lane_q <= lane_d;
                dout_q <= wdata;
                ct_q   <= ct_d;
                byte_q <= BYTEX;
                oen_q  <= ct_d != CT_WRITE;
            end
            if (state_q == BCC_ST_SETUP) begin
                rdn_q <= ct_q != CT_READ;
                wrn_q <= ct_q != CT_WRITE ? '1 : byte_q ? ~mask : '0;
            end
            if (to_hold) begin
                rdn_q <= 1'b1;
                wrn_q <= '1;
                if (ct_q == CT_READ && !abort) din_q <= byte_q ? rbyte : DIN_BUS;
                if (abort) ct_q <= CT_FAULT;
            end
            if (state_q == BCC_ST_HOLD) oen_q <= 1'b1;
        end
    end

    assign ADDR_BUF = addr_q;
    assign DOUT_BUF = dout_q;
    assign WRN_BUF  = wrn_q;
    assign RDN_BUF  = rdn_q;
    assign DBUS_OEN = oen_q;
    assign DIN_OUT  = din_q;
    assign BUSY     = state_q != BCC_ST_IDLE;
    assign ACK      = state_q == BCC_ST_HOLD;
    assign ERR      = state_q == BCC_ST_HOLD && ct_q == CT_FAULT;
endmodule

// File: doc/bus_cycle_controller.md
Name: bus_cycle_controller

Overview:
- Parametrised successor to the CPU's address/data bus steering block. It adds a registered bus-cycle state machine with READY-driven wait states.
- Generalises to N byte lanes, with per-lane active-low write strobes and byte extraction on reads.
- Sits between the core's COMMIT-phase datapath (PC, ALU result, ALU B operand, register A) and external memory/IO.
- Reports completion (ACK) and faults (ERR) back to the sequencer.

Parameters:
- AW, 16, address width in bits.
- DW, 16, data width in bits; must be a multiple of 8. LANES = DW/8, LB = log2(LANES), and LB=0 when LANES=1.
- WAIT_MAX, 15, maximum READY-low cycles before timeout (used only with the optional feature).

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  1  start a bus cycle; sampled only in IDLE.
- ADDR_BUSX  in  2  address source select: PC_A, ALU_R, ALUB_DATA; any other code selects ALUB_DATA.
- PC_A, ALU_R, ALUB_DATA  in  AW each  address sources. ALU_R also supplies write data when DATA_BUSX is not REGA_DOUT.
- REGA_DOUT  in  DW  register A write data.
- DATA_BUSX  in  2  write data select: REGA_DOUT (steered), otherwise ALU_R zero-extended to DW.
- BYTEX, WRX, RDX  in  1 each  byte access, write request, read request.
- READY  in  1  memory ready; active high.
- DIN_BUS  in  DW  raw read data from memory.
- ADDR_BUF  out  AW  registered bus address.
- DOUT_BUF  out  DW  registered, lane-steered write data.
- WRN_BUF  out  LANES  per-lane write strobes; active low.
- RDN_BUF  out  1  read strobe; active low.
- DBUS_OEN  out  1  CPU data driver enable; active low.
- DIN_OUT  out  DW  aligned read data; byte reads are zero-extended.
- BUSY  out  1  high whenever the state is not IDLE.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle fault pulse, asserted together with ACK.

Behaviour:
- Reset, effective on the next CLK edge (including mid-cycle): state=IDLE, ADDR_BUF=0, DOUT_BUF=0, WRN_BUF=all 1, RDN_BUF=1, DBUS_OEN=1, DIN_OUT=0, ACK=0, ERR=0, wait counter=0.
- States: IDLE, SETUP, STROBE, WAIT, HOLD.
- IDLE, REQ=1 -> SETUP. On that same edge, latch:
  - ADDR_BUF = selected address.
  - lane = address[LB-1:0].
  - DOUT_BUF = steered data.
  - the cycle type.
- Cycle type precedence:
  - RDX & WRX -> fault.
  - word access (BYTEX=0, LANES>1) with lane!=0 -> fault (misaligned).
  - WRX -> write.
  - RDX -> read.
  - otherwise -> null cycle.
- Write steering:
  - BYTEX=1: DOUT_BUF = REGA_DOUT[7:0] placed in byte lane `lane`, other lanes 0.
  - BYTEX=0: DOUT_BUF = REGA_DOUT unmodified.
  - When DATA_BUSX selects ALU_R, no steering is applied.
- SETUP -> STROBE. Strobes stay high. DBUS_OEN=0 for writes.
- STROBE: strobes are asserted from the edge entering STROBE.
  - Read: RDN_BUF=0.
  - Write, BYTEX=1: WRN_BUF[lane]=0.
  - Write, BYTEX=0: all WRN_BUF=0.
  - Fault and null cycles: no strobes.
  - READY=1 -> HOLD; READY=0 -> WAIT.
  - Fault and null cycles go to HOLD regardless of READY.
- WAIT: strobes stay asserted; the wait counter increments each cycle. READY=1 -> HOLD.
- HOLD:
  - All strobes deassert on entry.
  - Reads capture DIN_OUT from DIN_BUS on the HOLD-entry edge. Byte read: DIN_OUT = {0, DIN_BUS lane byte}.
  - ACK=1 for exactly one cycle; ERR=1 on fault or timeout.
  - DBUS_OEN stays 0 through HOLD (data hold time), then returns to 1.
  - HOLD -> IDLE.
- Latency: REQ sampled at edge t0 -> ACK high during cycle t3 with zero waits, plus one cycle per wait cycle. Next REQ is accepted at edge t4.
- REQ while BUSY is ignored; no queuing.
- ADDR_BUF and DOUT_BUF hold their values in IDLE until the next accepted REQ.

Optional Feature:
- BUS_CYCLE_TIMEOUT_EN defined: when the wait counter reaches WAIT_MAX while READY=0, abort -> HOLD with strobes deasserted, ACK=1, ERR=1, and DIN_OUT unchanged.
- Undefined: WAIT persists indefinitely until READY or RESET; no counter logic is instantiated, and ERR is raised only for faults.

Decomposition:
- Shared package/constants file holds:
  - ADDR_BUSX_* and DATA_BUSX_* codes (existing values retained).
  - BCC_ST_* state encodings.
  - cycle-type codes: CT_NULL, CT_READ, CT_WRITE, CT_FAULT.
- One combinational sub-module, byte_lane_steer (parameter DW): write-data lane placement, per-lane strobe mask, and read-byte extraction.

Test Plan:
- Word write, DW=16: REQ, ADDR_BUSX=ALU_R=0x1234, REGA_DOUT=0xBEEF, WRX=1, READY=1 -> ADDR_BUF=0x1234, WRN_BUF=2'b00 only in cycle t2, DOUT_BUF=0xBEEF, DBUS_OEN=0 in t1..t3, ACK in t3, ERR=0.
- Byte write at odd address 0x0011, REGA_DOUT=0x55AA -> DOUT_BUF=0xAA00, WRN_BUF=2'b01 in t2, ACK in t3.
- Byte read at 0x0011, DIN_BUS=0xC37E, READY low for 3 cycles -> RDN_BUF=0 for 4 cycles, DIN_OUT=0x00C3, ACK in t6.
- Misaligned word write at 0x0013 -> no strobe ever low, ACK=ERR=1 in t3; RDX=WRX=1 -> same response.
- With BUS_CYCLE_TIMEOUT_EN and WAIT_MAX=4, READY stuck 0 on a read -> RDN_BUF=1 after 4 wait cycles, ACK=ERR=1, BUSY falls the next cycle.
- RESET=1 during WAIT of a write -> next edge: WRN_BUF all 1, DBUS_OEN=1, BUSY=0, no ACK; a REQ issued afterwards completes normally.
